// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake and decode bundle of the immediate-generation stage
interface imm_gen_stage_if #(
   parameter int XLEN = 32
);
   logic            IN_VALID;
   logic            IN_READY;
   logic [31:0]     INSTR;
   logic            FLUSH;
   logic            OUT_VALID;
   logic            OUT_READY;
   logic [31:0]     OUT_INSTR;
   logic [XLEN-1:0] OUT_IMM;
   logic [2:0]      OUT_IMM_TYPE;
   logic            OUT_ILLEGAL;

   modport master (
      output IN_VALID, INSTR, FLUSH, OUT_READY,
      input  IN_READY, OUT_VALID, OUT_INSTR, OUT_IMM, OUT_IMM_TYPE, OUT_ILLEGAL
   );

   modport slave (
      input  IN_VALID, INSTR, FLUSH, OUT_READY,
      output IN_READY, OUT_VALID, OUT_INSTR, OUT_IMM, OUT_IMM_TYPE, OUT_ILLEGAL
   );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - single registered stage decoding the RV32 immediate and format
module imm_gen_stage #(
   parameter int XLEN       = 32,
   parameter int ENABLE_CSR = 1
) (
   input logic           CLK,
   input logic           RST,
   imm_gen_stage_if.slave bus
);
   localparam logic [2:0] TYPE_R   = 3'd0;
   localparam logic [2:0] TYPE_I   = 3'd1;
   localparam logic [2:0] TYPE_S   = 3'd2;
   localparam logic [2:0] TYPE_B   = 3'd3;
   localparam logic [2:0] TYPE_U   = 3'd4;
   localparam logic [2:0] TYPE_J   = 3'd5;
   localparam logic [2:0] TYPE_CSR = 3'd6;

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_type;
   logic            dec_illegal;

   logic            valid_q, valid_d;
   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] imm_q, imm_d;
   logic [2:0]      type_q, type_d;
   logic            illegal_q, illegal_d;

   logic            in_ready;
   logic            accept;

   always_comb begin
      dec_imm     = '0;
      dec_type    = TYPE_R;
      dec_illegal = 1'b0;
      if (bus.INSTR[1:0] != 2'b11) begin
         dec_illegal = 1'b1;
      end else begin
         case (bus.INSTR[6:2])
            5'b01100: dec_type = TYPE_R;
            5'b00000, 5'b00100, 5'b11001, 5'b00011: begin
               dec_type = TYPE_I;
               dec_imm  = XLEN'($signed(bus.INSTR[31:20]));
            end
            5'b01000: begin
               dec_type = TYPE_S;
               dec_imm  = XLEN'($signed({bus.INSTR[31:25], bus.INSTR[11:7]}));
            end
            5'b11000: begin
               dec_type = TYPE_B;
               dec_imm  = XLEN'($signed({bus.INSTR[31], bus.INSTR[7], bus.INSTR[30:25],
                                         bus.INSTR[11:8], 1'b0}));
            end
            5'b01101, 5'b00101: begin
               dec_type = TYPE_U;
               dec_imm  = XLEN'($signed({bus.INSTR[31:12], 12'h000}));
            end
            5'b11011: begin
               dec_type = TYPE_J;
               dec_imm  = XLEN'($signed({bus.INSTR[31], bus.INSTR[19:12], bus.INSTR[20],
                                         bus.INSTR[30:21], 1'b0}));
            end
            5'b11100: begin
               // Only the immediate CSR forms (funct3[2] set) carry zimm in rs1.
               if (ENABLE_CSR == 1 && bus.INSTR[14]) begin
                  dec_type = TYPE_CSR;
                  dec_imm  = XLEN'(bus.INSTR[19:15]);
               end else begin
                  dec_type = TYPE_I;
                  dec_imm  = XLEN'($signed(bus.INSTR[31:20]));
               end
            end
            default: dec_illegal = 1'b1;
         endcase
      end
   end

   assign in_ready = ~RST & (~valid_q | bus.OUT_READY | bus.FLUSH);
   assign accept   = bus.IN_VALID & in_ready & ~bus.FLUSH;

   always_comb begin
      valid_d   = valid_q;
      instr_d   = instr_q;
      imm_d     = imm_q;
      type_d    = type_q;
      illegal_d = illegal_q;
      if (bus.FLUSH) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d   = 1'b1;
         instr_d   = bus.INSTR;
         imm_d     = dec_imm;
         type_d    = dec_type;
         illegal_d = dec_illegal;
      end else if (bus.OUT_READY) begin
         valid_d = 1'b0;
      end
   end

   // Reset contents describe a decoded NOP so downstream sees a benign bundle.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         valid_q   <= 1'b0;
         instr_q   <= 32'h0000_0013;
         imm_q     <= '0;
         type_q    <= TYPE_I;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         instr_q   <= instr_d;
         imm_q     <= imm_d;
         type_q    <= type_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.IN_READY     = in_ready;
   assign bus.OUT_VALID    = valid_q;
   assign bus.OUT_INSTR    = instr_q;
   assign bus.OUT_IMM      = imm_q;
   assign bus.OUT_IMM_TYPE = type_q;
   assign bus.OUT_ILLEGAL  = illegal_q;
endmodule
